alu_mul_ctrl: RTL and testbench

ALU_MUL_CTRL -- requirements
Module: alu_mul_ctrl

---
 rtl/alu_mul_ctrl_pkg.sv | 29 ++
 rtl/alu_mul_ctrl_rca8.sv | 31 +++
 rtl/alu_mul_ctrl.sv | 111 +++++++++++
 tb/tb_alu_mul_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_ctrl_pkg.sv
// ============================================================================
// Module  : alu_mul_ctrl_pkg
// Brief   : Shared encodings and constants for the shift-add multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_mul_ctrl_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned ITER  = 8;
  localparam int unsigned CNT_W = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

  // The adder B operand is the multiplicand when the current multiplier bit is set.
  function automatic logic [WIDTH-1:0] gate_operand(input logic sel, input logic [WIDTH-1:0] m);
    return sel ? m : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mul_ctrl_rca8.sv
// ============================================================================
// Module  : rca8
// Brief   : 8-bit ripple-carry adder shared across the ALU datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rca8 (
  output logic       Cout,
  output logic [7:0] Sum,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin
);

  logic [8:0] w_carry;

  assign w_carry[0] = Cin;

  generate
    for (genvar i = 0; i < 8; i++) begin : g_bit
      assign Sum[i]         = A[i] ^ B[i] ^ w_carry[i];
      assign w_carry[i + 1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
    end
  endgenerate

  assign Cout = w_carry[8];

endmodule

`default_nettype wire

// File: rtl/alu_mul_ctrl.sv
// ============================================================================
// Module  : alu_mul_ctrl
// Brief   : 8x8 unsigned shift-add multiplier sequencing one shared rca8.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_ctrl
  import alu_mul_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] shifted;
  logic               accept;

  assign accept  = start && ((state_q == IDLE) || (state_q == DONE));
  assign add_b   = gate_operand(mq_q[0], m_q);
  // Carry-out becomes the new top bit of ACC, so the pair never overflows.
  assign shifted = {add_cout, add_sum, mq_q[WIDTH-1:1]};

  rca8 u_rca8 (
    .Cout (add_cout),
    .Sum  (add_sum),
    .A    (acc_q),
    .B    (add_b),
    .Cin  (1'b0)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
  end

  always_comb begin
    cnt_d     = cnt_q;
    m_d       = m_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    product_d = product_q;
    if (accept) begin
      m_d   = a;
      mq_d  = b;
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == CALC) begin
      {acc_d, mq_d} = shifted;
      cnt_d         = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        product_d = shifted;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      product_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_ctrl.sv
// ============================================================================
// Module  : tb_alu_mul_ctrl
// Brief   : Scoreboard bench for alu_mul_ctrl with directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mul_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a     = 8'd0;
  logic [7:0]  b     = 8'd0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  typedef struct {
    logic [15:0] prod;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks    = 0;
  int          errors    = 0;
  int          cyc       = 0;
  int          busy_cnt  = 0;
  logic [15:0] last_prod = 16'd0;

  alu_mul_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  // Latency 8 = edge index of DONE minus accept edge, i.e. done occupies the 9th cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: product 0x%0h with nothing pending", product);
        end else begin
          mon_e = sb.pop_front();
          check("product", {16'd0, product}, {16'd0, mon_e.prod});
          check("latency", cyc - mon_e.acc_cyc, 8);
          check("busy_cycles", busy_cnt, 8);
          check("busy_done_exclusive", {31'd0, busy}, 32'd0);
          last_prod = mon_e.prod;
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [7:0] av, input logic [7:0] bv,
                       input logic [15:0] exp_prod, input bit push);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{exp_prod, cyc});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: %0d results still pending, expected 0", name, sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
    check({"product_hold_", name}, {16'd0, product}, {16'd0, last_prod});
  endtask

  initial begin
    int n;
    // Reset with start held high: must stay idle and cleared.
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'd5;
    b     = 8'd5;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_product", {16'd0, product}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {31'd0, busy}, 32'd0);

    issue(8'd13, 8'd11, 16'd143, 1'b1);
    wait_idle("13x11");
    issue(8'hFF, 8'hFF, 16'hFE01, 1'b1);
    wait_idle("ffxff");
    issue(8'h00, 8'hA5, 16'h0000, 1'b1);
    wait_idle("00xa5");
    issue(8'hA5, 8'h00, 16'h0000, 1'b1);
    wait_idle("a5x00");
    issue(8'h01, 8'h80, 16'h0080, 1'b1);
    wait_idle("01x80");

    // Start during CALC cycle 4 must be ignored.
    issue(8'd3, 8'd5, 16'd15, 1'b1);
    repeat (3) @(negedge clk);
    a     = 8'd9;
    b     = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ignore_start");

    // Start held through DONE: back-to-back run with no IDLE cycle.
    issue(8'd6, 8'd7, 16'd42, 1'b1);
    a     = 8'd2;
    b     = 8'd7;
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (done !== 1'b1 && n < 20);
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout_b2b: done got %b, expected 1", done);
    end else begin
      @(posedge clk);
      #1;
      sb.push_back('{16'd14, cyc});
      check("b2b_restart_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle("b2b");

    // Reset in CALC cycle 5 aborts the run; start during reset is ignored.
    issue(8'hC8, 8'h64, 16'h0000, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'd9;
    b     = 8'd9;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_product", {16'd0, product}, 32'd0);
    rst_n     = 1'b1;
    start     = 1'b0;
    last_prod = 16'd0;
    repeat (12) @(negedge clk);
    check("abort_product_stays", {16'd0, product}, 32'd0);
    issue(8'hC8, 8'h64, 16'h4E20, 1'b1);
    wait_idle("c8x64");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
